pwm_controller: RTL and testbench

Drives the 16 chip outputs from the configuration registers written over SPI: output-enable, PWM-enable and the shared 8-bit duty cycle. It sequences a prescaler and an 8-bit period counter. Duty and enable values for PWM-mode bits are shadowed and applied only at period boundaries, so a mid-period SPI write never produces a glitch pulse. It sits between the SPI register block and the top-level output pins.

---
 rtl/pwm_controller.sv | 164 ++++++++++++++++
 tb/tb_pwm_controller.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_controller.sv
// pwm_controller
//   Drives the 16 chip output pins from the SPI configuration registers.
//   A prescaler produces one count tick every PRESCALE_DIV clocks. An 8-bit
//   period counter advances on each tick, so one PWM period is
//   256*PRESCALE_DIV clocks.
//   Duty and enable values for PWM-mode bits are shadowed. They are applied
//   only at period boundaries, so a mid-period register write cannot produce
//   a glitch pulse. Output disable and static-high changes bypass the shadows
//   and take effect on the next clock.
//
// Optional feature (macro PWM_PERIOD_STATUS_EN):
//   Adds the output period_start. It is a registered one-clock pulse that
//   marks the first cycle on which pwm_out reflects newly loaded shadows.
//
// Parameters:
//   PRESCALE_DIV   clk cycles per PWM count tick, 1..65535
//   PRESCALE_W     prescaler counter width
//
// Ports:
//   clk              system clock
//   rst_n            asynchronous active-low reset
//   en_reg_out_7_0   output enable, bits 7:0
//   en_reg_out_15_8  output enable, bits 15:8
//   en_reg_pwm_7_0   PWM-mode enable, bits 7:0
//   en_reg_pwm_15_8  PWM-mode enable, bits 15:8
//   pwm_duty_cycle   shared duty value
//   pwm_out          registered output pins; bit i follows enable bit i
//   period_start     (PWM_PERIOD_STATUS_EN only) period start pulse
//
// The FSM state is held in `state` (IDLE/RUN) so that checkers can bind to it.

module pwm_controller #(
  parameter int unsigned PRESCALE_DIV = 13,
  parameter int unsigned PRESCALE_W   = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  en_reg_out_7_0,
  input  logic [7:0]  en_reg_out_15_8,
  input  logic [7:0]  en_reg_pwm_7_0,
  input  logic [7:0]  en_reg_pwm_15_8,
  input  logic [7:0]  pwm_duty_cycle,
  output logic [15:0] pwm_out
`ifdef PWM_PERIOD_STATUS_EN
  ,
  output logic        period_start
`endif
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [PRESCALE_W-1:0] PRE_LAST = PRESCALE_W'(PRESCALE_DIV - 1);
  localparam logic [PRESCALE_W-1:0] PRE_ONE  = PRESCALE_W'(1);

  logic [0:0]            state;
  logic [PRESCALE_W-1:0] pre_cnt;
  logic [7:0]            pwm_cnt;
  logic [7:0]            duty_sh;
  logic [15:0]           en_out_sh;
  logic [15:0]           en_pwm_sh;

  logic [15:0] en_out;
  logic [15:0] en_pwm;
  logic        run_req;
  logic        tick;
  logic        wrap;
  logic        shadow_load;
  logic        pwm_level;
  logic [15:0] pwm_next;

  assign en_out  = {en_reg_out_15_8, en_reg_out_7_0};
  assign en_pwm  = {en_reg_pwm_15_8, en_reg_pwm_7_0};
  assign run_req = |(en_out & en_pwm);

  // The counters are held at zero in IDLE, so ticks only exist in RUN.
  // This also covers PRESCALE_DIV=1, where pre_cnt==PRE_LAST always holds.
  assign tick = (state == RUN) && (pre_cnt == PRE_LAST);
  assign wrap = tick && (pwm_cnt == 8'hFF);

  // Shadows follow the live registers every cycle in IDLE and only at the
  // period boundary in RUN. The IDLE->RUN cycle is included in the IDLE case.
  assign shadow_load = (state == IDLE) || wrap;

  // Duty 0xFF is forced high so that full scale means always on. With the
  // plain compare it would be low on count 255.
  assign pwm_level = (duty_sh == 8'hFF) || (pwm_cnt < duty_sh);

  // Per-bit priority:
  //   en_out=0                    -> 0
  //   en_pwm=0                    -> 1 (static high)
  //   shadowed out & pwm enables  -> pwm_level
  //   otherwise                   -> 0
  // The last case is a bit newly put in PWM mode that is waiting for the
  // next period start.
  assign pwm_next = en_out & (~en_pwm | (en_out_sh & en_pwm_sh & {16{pwm_level}}));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (run_req) state <= RUN;
        RUN:     if (wrap && !run_req) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt <= '0;
      pwm_cnt <= '0;
    end else if (state != RUN) begin
      pre_cnt <= '0;
      pwm_cnt <= '0;
    end else if (tick) begin
      // On a wrap, pwm_cnt rolls from 255 to 0. This leaves both counters
      // cleared whether the FSM stays in RUN or drops back to IDLE.
      pre_cnt <= '0;
      pwm_cnt <= pwm_cnt + 8'd1;
    end else begin
      pre_cnt <= pre_cnt + PRE_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_sh   <= '0;
      en_out_sh <= '0;
      en_pwm_sh <= '0;
    end else if (shadow_load) begin
      duty_sh   <= pwm_duty_cycle;
      en_out_sh <= en_out;
      en_pwm_sh <= en_pwm;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_out <= '0;
    end else begin
      pwm_out <= pwm_next;
    end
  end

`ifdef PWM_PERIOD_STATUS_EN
  // Shadows load on edge N, and pwm_out first reflects them on edge N+1.
  // The load event is therefore delayed by one register so that the pulse
  // lines up with that pwm_out update.
  logic load_evt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_evt_q   <= 1'b0;
      period_start <= 1'b0;
    end else begin
      load_evt_q   <= wrap || ((state == IDLE) && run_req);
      period_start <= load_evt_q;
    end
  end
`endif

endmodule

// File: tb/tb_pwm_controller.sv
// tb_pwm_controller
//   Directed bench for pwm_controller, built with PRESCALE_DIV=2 so that one
//   PWM period is 512 clocks. Inputs are driven 1 time unit after each rising
//   edge, and outputs are sampled at the same point.

module tb_pwm_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  en_reg_out_7_0;
  logic [7:0]  en_reg_out_15_8;
  logic [7:0]  en_reg_pwm_7_0;
  logic [7:0]  en_reg_pwm_15_8;
  logic [7:0]  pwm_duty_cycle;
  logic [15:0] pwm_out;
`ifdef PWM_PERIOD_STATUS_EN
  logic        period_start;
`endif

  int total = 0;
  int bad   = 0;

  pwm_controller #(.PRESCALE_DIV(2), .PRESCALE_W(16)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .en_reg_out_7_0  (en_reg_out_7_0),
    .en_reg_out_15_8 (en_reg_out_15_8),
    .en_reg_pwm_7_0  (en_reg_pwm_7_0),
    .en_reg_pwm_15_8 (en_reg_pwm_15_8),
    .pwm_duty_cycle  (pwm_duty_cycle),
    .pwm_out         (pwm_out)
`ifdef PWM_PERIOD_STATUS_EN
    ,
    .period_start    (period_start)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_en(input logic [15:0] o, input logic [15:0] p);
    en_reg_out_7_0  = o[7:0];
    en_reg_out_15_8 = o[15:8];
    en_reg_pwm_7_0  = p[7:0];
    en_reg_pwm_15_8 = p[15:8];
  endtask

  // Counts consecutive samples, starting at the current one, for which
  // pwm_out[0] equals lvl. When the count reaches change_at, duty is rewritten.
  task automatic run_len(input logic lvl, input int change_at,
                         input logic [7:0] new_duty, output int len);
    len = 0;
    while (pwm_out[0] === lvl && len < 4000) begin
      len++;
      if (len == change_at) pwm_duty_cycle = new_duty;
      step();
    end
  endtask

  // Advances to the first sample where pwm_out[0] has gone from 0 to 1.
  task automatic wait_rise(input string name);
    logic prev;
    bit   found;
    int   n;
    found = 0;
    n     = 0;
    prev  = pwm_out[0];
    while (!found && n < 3000) begin
      step();
      n++;
      if (prev === 1'b0 && pwm_out[0] === 1'b1) found = 1;
      prev = pwm_out[0];
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL %s: no rising edge within %0d clk, required one", name, n);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    set_en(16'hFFFF, 16'hFFFF);
    pwm_duty_cycle = 8'h80;
    for (int i = 0; i < 5; i++) begin
      step();
      total++;
      if (pwm_out !== 16'h0000) begin
        bad++;
        $display("FAIL reset_out[%0d]: got %h, required 0000", i, pwm_out);
      end
    end
    set_en(16'h0000, 16'h0000);
    rst_n = 1'b1;
    total++;
    if (dut.state !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: got %b, required IDLE(0)", dut.state);
    end
    step();
    total++;
    if (dut.state !== 1'b0 || pwm_out !== 16'h0000) begin
      bad++;
      $display("FAIL post_reset_idle: state=%b out=%h, required 0 / 0000", dut.state, pwm_out);
    end
  endtask

  task automatic test_static();
    set_en(16'h0001, 16'h0000);
    step();
    total++;
    if (pwm_out !== 16'h0001 || dut.state !== 1'b0) begin
      bad++;
      $display("FAIL static_bit0: out=%h state=%b, required 0001 / IDLE", pwm_out, dut.state);
    end
    set_en(16'h8001, 16'h0000);
    step();
    total++;
    if (pwm_out !== 16'h8001) begin
      bad++;
      $display("FAIL static_bit15: got %h, required 8001", pwm_out);
    end
    set_en(16'h0001, 16'h0000);
    step();
    total++;
    if (pwm_out !== 16'h0001) begin
      bad++;
      $display("FAIL static_drop15: got %h, required 0001", pwm_out);
    end
  endtask

  task automatic test_pwm_half();
    int len;
    pwm_duty_cycle = 8'h80;
    set_en(16'h0001, 16'h0001);
    step();
    // Entry edge: the FSM moves to RUN, and the shadowed PWM enable is still
    // 0, so the bit is held low.
    total++;
    if (dut.state !== 1'b1 || pwm_out !== 16'h0000) begin
      bad++;
      $display("FAIL run_entry: state=%b out=%h, required RUN / 0000", dut.state, pwm_out);
    end
`ifdef PWM_PERIOD_STATUS_EN
    total++;
    if (period_start !== 1'b0) begin
      bad++;
      $display("FAIL ps_early: got %b, required 0", period_start);
    end
`endif
    step();
    total++;
    if (pwm_out !== 16'h0001) begin
      bad++;
      $display("FAIL first_high: got %h, required 0001", pwm_out);
    end
`ifdef PWM_PERIOD_STATUS_EN
    total++;
    if (period_start !== 1'b1) begin
      bad++;
      $display("FAIL ps_entry: got %b, required 1", period_start);
    end
`endif
    run_len(1'b1, 0, 8'h00, len);
    total++;
    if (len != 256) begin bad++; $display("FAIL half_high1: got %0d clk, required 256", len); end
    run_len(1'b0, 0, 8'h00, len);
    total++;
    if (len != 256) begin bad++; $display("FAIL half_low1: got %0d clk, required 256", len); end
    run_len(1'b1, 0, 8'h00, len);
    total++;
    if (len != 256) begin bad++; $display("FAIL half_high2: got %0d clk, required 256", len); end
  endtask

  task automatic test_duty_extremes();
    int highs;
    int lows;
    int pulses;
    pwm_duty_cycle = 8'h00;
    repeat (600) step();
    highs  = 0;
    pulses = 0;
    for (int i = 0; i < 1536; i++) begin
      if (pwm_out[0] !== 1'b0) highs++;
`ifdef PWM_PERIOD_STATUS_EN
      if (period_start === 1'b1) pulses++;
`endif
      step();
    end
    total++;
    if (highs != 0) begin bad++; $display("FAIL duty00: got %0d high clk, required 0", highs); end
`ifdef PWM_PERIOD_STATUS_EN
    total++;
    if (pulses != 3) begin bad++; $display("FAIL ps_count: got %0d pulses, required 3", pulses); end
`endif
    pwm_duty_cycle = 8'hFF;
    repeat (600) step();
    lows = 0;
    for (int i = 0; i < 1536; i++) begin
      if (pwm_out[0] !== 1'b1) lows++;
      step();
    end
    total++;
    if (lows != 0) begin bad++; $display("FAIL dutyFF: got %0d low clk, required 0", lows); end
  endtask

  task automatic test_mid_change();
    int len;
    pwm_duty_cycle = 8'h40;
    repeat (600) step();
    wait_rise("mid_sync");
    // The duty write lands 20 clocks into the high phase. The current period
    // must keep the 0x40 profile.
    run_len(1'b1, 20, 8'hC0, len);
    total++;
    if (len != 128) begin bad++; $display("FAIL mid_old_high: got %0d clk, required 128", len); end
    run_len(1'b0, 0, 8'h00, len);
    total++;
    if (len != 384) begin bad++; $display("FAIL mid_old_low: got %0d clk, required 384", len); end
    run_len(1'b1, 0, 8'h00, len);
    total++;
    if (len != 384) begin bad++; $display("FAIL mid_new_high: got %0d clk, required 384", len); end
  endtask

  task automatic test_disable_and_reset();
    int n;
    wait_rise("dis_sync");
    repeat (20) step();   // pwm_cnt is now 10
    total++;
    if (pwm_out[0] !== 1'b1) begin
      bad++;
      $display("FAIL pre_disable: got %b, required 1", pwm_out[0]);
    end
    set_en(16'h0000, 16'h0001);
    step();
    total++;
    if (pwm_out !== 16'h0000) begin
      bad++;
      $display("FAIL out_disable: got %h, required 0000", pwm_out);
    end
    // Output enabled but no PWM bits: static high at once, idle at next wrap.
    set_en(16'h0001, 16'h0000);
    step();
    total++;
    if (pwm_out !== 16'h0001 || dut.state !== 1'b1) begin
      bad++;
      $display("FAIL pwm_clear: out=%h state=%b, required 0001 / RUN", pwm_out, dut.state);
    end
    n = 0;
    while (dut.state !== 1'b0 && n < 600) begin
      step();
      n++;
    end
    total++;
    if (n == 0 || n > 512) begin
      bad++;
      $display("FAIL idle_return: took %0d clk, required 1..512", n);
    end
    total++;
    if (pwm_out !== 16'h0001 || dut.pwm_cnt !== 8'h00) begin
      bad++;
      $display("FAIL idle_state: out=%h cnt=%h, required 0001 / 00", pwm_out, dut.pwm_cnt);
    end
    // Restart PWM, then hit reset between clock edges.
    set_en(16'h0001, 16'h0001);
    repeat (50) step();
    total++;
    if (pwm_out !== 16'h0001) begin
      bad++;
      $display("FAIL prerst_high: got %h, required 0001", pwm_out);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (pwm_out !== 16'h0000 || dut.state !== 1'b0 || dut.pwm_cnt !== 8'h00) begin
      bad++;
      $display("FAIL async_reset: out=%h state=%b cnt=%h, required 0000 / 0 / 00",
               pwm_out, dut.state, dut.pwm_cnt);
    end
    step();
    rst_n = 1'b1;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst_n = 1'b0;
    set_en(16'h0000, 16'h0000);
    pwm_duty_cycle = 8'h00;
    test_reset();
    test_static();
    test_pwm_half();
    test_duty_extremes();
    test_mid_change();
    test_disable_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
